// File: rtl/conv_acc.sv
// -----------------------------------------------------------------------------
// conv_acc - convolution accumulation stage
//
// Adds each accepted product beat (m_data1) to either a bias vector (first
// kernel pass) or a stored partial sum (later passes), lane by lane, with a
// registered one-cycle result. Final-pass results leave on m_sum/m_valid;
// intermediate results leave on s_sum/s_valid for partial-sum write-back.
// Bias and partial-sum memories are combinational-read: the address driven
// this cycle returns its data (m_data2 / m_data3) in the same cycle.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   m_data1, m_valid1  product beat in; accepted when m_valid1 && m_ready
//   m_ready            high while a job is ACTIVE
//   m_data2, m_data3   bias / partial-sum read data for m_addr2 / m_addr3
//   base2, size        bias base address and job length in beats (latched)
//   start              one-cycle job start pulse (ignored while ACTIVE)
//   first_k, last_k    pass selectors: add bias / route to m_sum (latched)
//   m_addr2, m_addr3   bias / partial-sum read addresses
//   m_sum, m_valid     final result and its one-cycle valid
//   s_sum, s_valid     intermediate result and its one-cycle valid
// -----------------------------------------------------------------------------
module conv_acc #(
    parameter int AW = 8,
    parameter int DW = 22,
    parameter int DN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW*DN-1:0] m_data1,
    input  logic             m_valid1,
    output logic             m_ready,
    input  logic [DW*DN-1:0] m_data2,
    input  logic [DW*DN-1:0] m_data3,
    input  logic [AW-1:0]    base2,
    input  logic [10:0]      size,
    input  logic             start,
    input  logic             first_k,
    input  logic             last_k,
    output logic [AW-1:0]    m_addr2,
    output logic [AW-1:0]    m_addr3,
    output logic [DW*DN-1:0] m_sum,
    output logic             m_valid,
    output logic [DW*DN-1:0] s_sum,
    output logic             s_valid
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [10:0]      cnt;
    logic [10:0]      size_reg;
    logic [AW-1:0]    base_reg;
    logic             first_reg;
    logic             last_reg;
    logic             accept;
    logic             last_beat;
    logic [DW*DN-1:0] result;

    // m_ready comes straight from the state register, so it rises the cycle
    // after start is sampled and falls the cycle after the last beat.
    assign m_ready   = (state_q == ACTIVE);
    assign accept    = m_valid1 && m_ready;
    assign last_beat = (cnt == size_reg - 11'd1);

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // values from before the edge; combinational blocks use blocking (=).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (size != 11'd0)) state_d = ACTIVE;
            ACTIVE:  if (accept && last_beat)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------- job registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            size_reg  <= '0;
            base_reg  <= '0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            cnt       <= '0;
            size_reg  <= size;
            base_reg  <= base2;
            first_reg <= first_k;
            last_reg  <= last_k;
        end else if (accept) begin
            cnt <= cnt + 11'd1;
        end
    end

    // After a job cnt is left at size, so IDLE forces the idle addresses
    // instead of exposing the stale count.
    assign m_addr2 = (state_q == ACTIVE) ? base_reg + AW'(cnt) : base_reg;
    assign m_addr3 = (state_q == ACTIVE) ? AW'(cnt) : '0;

    // ---------------------------------------------------- lane adders
    // Two's-complement add truncated to DW bits wraps exactly like a signed
    // add, so no sign handling is needed here.
    for (genvar i = 0; i < DN; i++) begin : g_lane
        assign result[i*DW +: DW] = m_data1[i*DW +: DW] +
                                    (first_reg ? m_data2[i*DW +: DW]
                                               : m_data3[i*DW +: DW]);
    end

    // ---------------------------------------------------- result registers
    // Only the destination sum register loads; the other keeps its value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_sum   <= '0;
            s_sum   <= '0;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            m_valid <= accept && last_reg;
            s_valid <= accept && !last_reg;
            if (accept && last_reg)  m_sum <= result;
            if (accept && !last_reg) s_sum <= result;
        end
    end

endmodule

// File: tb/tb_conv_acc.sv
// -----------------------------------------------------------------------------
// tb_conv_acc - directed self-checking bench for conv_acc (AW=8, DW=22, DN=1).
// Inputs change 1 ns after each rising edge; outputs are sampled there too,
// so every registered result of a beat accepted at edge N is checked right
// after edge N, and combinational addresses are checked before the next edge.
// -----------------------------------------------------------------------------
module tb_conv_acc;

    localparam int AW = 8;
    localparam int DW = 22;
    localparam int DN = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW*DN-1:0] m_data1;
    logic             m_valid1;
    logic             m_ready;
    logic [DW*DN-1:0] m_data2;
    logic [DW*DN-1:0] m_data3;
    logic [AW-1:0]    base2;
    logic [10:0]      size;
    logic             start;
    logic             first_k;
    logic             last_k;
    logic [AW-1:0]    m_addr2;
    logic [AW-1:0]    m_addr3;
    logic [DW*DN-1:0] m_sum;
    logic             m_valid;
    logic [DW*DN-1:0] s_sum;
    logic             s_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv_acc #(.AW(AW), .DW(DW), .DN(DN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_data1  (m_data1),
        .m_valid1 (m_valid1),
        .m_ready  (m_ready),
        .m_data2  (m_data2),
        .m_data3  (m_data3),
        .base2    (base2),
        .size     (size),
        .start    (start),
        .first_k  (first_k),
        .last_k   (last_k),
        .m_addr2  (m_addr2),
        .m_addr3  (m_addr3),
        .m_sum    (m_sum),
        .m_valid  (m_valid),
        .s_sum    (s_sum),
        .s_valid  (s_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // A signed integer as a zero-extended DW-bit pattern.
    function automatic logic [31:0] d22(input int v);
        logic [DW-1:0] t;
        t = DW'(v);
        return {{(32-DW){1'b0}}, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int b, input int sz, input logic f, input logic l);
        base2   = AW'(b);
        size    = 11'(sz);
        first_k = f;
        last_k  = l;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic drive(input logic v, input int d1, input int d2, input int d3);
        m_valid1 = v;
        m_data1  = DW'(d1);
        m_data2  = DW'(d2);
        m_data3  = DW'(d3);
    endtask

    int bias_d1[8] = '{15, 20, -30, -50, 7, 5, 99, 125};
    int bias_d2[8] = '{8, 11, -9, 11, 1, -17, 50, 111};
    int bias_ex[8] = '{23, 31, -39, -39, 8, -12, 149, 236};
    int extra_d1[4] = '{11, 11, 12, 13};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base2 = '0;
        size = '0;
        first_k = 1'b0;
        last_k = 1'b0;
        drive(1'b0, 0, 0, 0);

        // ---- 1. reset, with a start pulse that must be ignored
        @(posedge clk);
        #1;
        base2 = 8'd33;
        size  = 11'd5;
        start = 1'b1;
        step();
        step();
        check("rst m_ready", m_ready, 0);
        check("rst m_valid", m_valid, 0);
        check("rst s_valid", s_valid, 0);
        check("rst m_sum", m_sum, 0);
        check("rst s_sum", s_sum, 0);
        check("rst m_addr2", m_addr2, 0);
        check("rst m_addr3", m_addr3, 0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check("post-rst m_ready", m_ready, 0);

        // ---- 2. bias pass
        start_job(10, 8, 1'b1, 1'b0);
        check("bias m_ready", m_ready, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bias_d1[i], bias_d2[i], 777);
            check($sformatf("bias addr2[%0d]", i), m_addr2, 10 + i);
            check($sformatf("bias addr3[%0d]", i), m_addr3, i);
            step();
            check($sformatf("bias s_valid[%0d]", i), s_valid, 1);
            check($sformatf("bias s_sum[%0d]", i), s_sum, d22(bias_ex[i]));
            check($sformatf("bias m_valid[%0d]", i), m_valid, 0);
        end
        check("bias m_ready drop", m_ready, 0);
        check("bias idle addr2", m_addr2, 10);
        check("bias idle addr3", m_addr3, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, extra_d1[i], 22, 0);
            step();
            check($sformatf("extra s_valid[%0d]", i), s_valid, 0);
            check($sformatf("extra m_valid[%0d]", i), m_valid, 0);
            check($sformatf("extra s_sum[%0d]", i), s_sum, 236);
        end
        drive(1'b0, 0, 0, 0);

        // ---- 3. final pass from partial sums
        start_job(0, 4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i + 1, 555, 100);
            check($sformatf("final addr3[%0d]", i), m_addr3, i);
            step();
            check($sformatf("final m_valid[%0d]", i), m_valid, 1);
            check($sformatf("final m_sum[%0d]", i), m_sum, 101 + i);
            check($sformatf("final s_valid[%0d]", i), s_valid, 0);
        end
        check("final s_sum held", s_sum, 236);
        check("final m_ready drop", m_ready, 0);
        drive(1'b0, 0, 0, 0);
        step();
        check("final m_valid pulse ends", m_valid, 0);

        // ---- 4. stall mid-job
        start_job(40, 4, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 10 + i, 1000, 0);
            step();
            check($sformatf("stall pre s_sum[%0d]", i), s_sum, 1010 + i);
        end
        drive(1'b0, 99, 99, 99);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall addr2[%0d]", i), m_addr2, 42);
            check($sformatf("stall addr3[%0d]", i), m_addr3, 2);
            check($sformatf("stall s_valid[%0d]", i), s_valid, 0);
            check($sformatf("stall m_ready[%0d]", i), m_ready, 1);
        end
        for (int i = 2; i < 4; i++) begin
            drive(1'b1, 10 + i, 1000, 0);
            step();
            check($sformatf("stall post s_sum[%0d]", i), s_sum, 1010 + i);
        end
        check("stall m_ready drop", m_ready, 0);
        drive(1'b0, 0, 0, 0);

        // ---- 5. address wrap and arithmetic overflow
        start_job(254, 4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b1, (1 << 21) - 1, 1, 0);
            else        drive(1'b1, 1, 2, 0);
            check($sformatf("wrap addr2[%0d]", i), m_addr2, (254 + i) % 256);
            step();
            check($sformatf("wrap s_sum[%0d]", i), s_sum, (i == 0) ? d22(-(1 << 21)) : 3);
        end
        drive(1'b0, 0, 0, 0);

        // ---- 6a. size = 0 job never activates
        start_job(77, 0, 1'b1, 1'b1);
        check("size0 m_ready", m_ready, 0);
        check("size0 addr2", m_addr2, 77);
        drive(1'b1, 5, 5, 5);
        step();
        check("size0 m_valid", m_valid, 0);
        check("size0 s_valid", s_valid, 0);
        drive(1'b0, 0, 0, 0);

        // ---- 6b. start during ACTIVE is ignored
        start_job(100, 3, 1'b0, 1'b0);
        drive(1'b1, 1, 9000, 50);
        step();
        check("busy s_sum[0]", s_sum, 51);
        base2 = 8'd5;
        size = 11'd1;
        first_k = 1'b1;
        last_k = 1'b1;
        start = 1'b1;
        drive(1'b1, 2, 9000, 50);
        check("busy addr2[1]", m_addr2, 101);
        step();
        start = 1'b0;
        check("busy s_sum[1]", s_sum, 52);
        check("busy m_valid[1]", m_valid, 0);
        check("busy m_ready", m_ready, 1);
        drive(1'b1, 3, 9000, 50);
        check("busy addr2[2]", m_addr2, 102);
        step();
        check("busy s_sum[2]", s_sum, 53);
        check("busy m_ready drop", m_ready, 0);
        drive(1'b0, 0, 0, 0);

        // ---- reset mid-job aborts
        start_job(0, 4, 1'b1, 1'b0);
        drive(1'b1, 4, 4, 0);
        step();
        check("abort pre s_sum", s_sum, 8);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort m_ready", m_ready, 0);
        check("abort s_valid", s_valid, 0);
        check("abort s_sum", s_sum, 0);
        step();
        check("abort no restart", m_ready, 0);
        check("abort no output", s_valid, 0);
        drive(1'b0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_acc.md
Name: conv_acc

Overview:
- Convolution accumulation stage. It adds a stream of convolution products (m_data1) to either a bias vector (first kernel pass) or a stored partial sum (later passes).
- It generates read addresses for the bias memory and the partial-sum memory.
- Final-pass results go downstream on m_sum. Intermediate results go back to partial-sum storage on s_sum.
- It sits between the MAC array output and the partial-sum / output buffers.

Parameters:
- AW, 8, address width of bias and partial-sum memories.
- DW, 22, width of one signed data lane.
- DN, 1, number of parallel lanes; all data buses are DW*DN bits, lane i = bits [i*DW +: DW].

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- m_data1  input  DW*DN  product data beat.
- m_valid1  input  1  m_data1 valid.
- m_ready  output  1  block accepts beats; high only while ACTIVE.
- m_data2  input  DW*DN  bias read data for m_addr2 (combinational-read memory, same cycle).
- m_data3  input  DW*DN  partial-sum read data for m_addr3 (same cycle).
- base2  input  AW  bias base address, latched at start.
- size  input  11  number of beats in the job, latched at start.
- start  input  1  one-cycle job start pulse.
- first_k  input  1  first kernel pass: add bias; latched at start.
- last_k  input  1  last kernel pass: route result to m_sum; latched at start.
- m_addr2  output  AW  bias read address.
- m_addr3  output  AW  partial-sum read address.
- m_sum  output  DW*DN  final accumulated result.
- m_valid  output  1  m_sum valid, one-cycle pulse per beat.
- s_sum  output  DW*DN  intermediate result for partial-sum write-back.
- s_valid  output  1  s_sum valid, one-cycle pulse per beat.

Behaviour:
- The interface uses one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - FSM = IDLE; beat counter cnt = 0; latched base, size, first and last registers = 0.
  - m_ready = 0; m_sum = 0; s_sum = 0; m_valid = 0; s_valid = 0.
  - Reset asserted mid-job aborts the job; no further outputs are produced.
- FSM states: IDLE, ACTIVE.
  - IDLE: when start = 1 at a clock edge, latch base2, size, first_k and last_k, and clear cnt. If the latched size is nonzero, go to ACTIVE; size = 0 stays IDLE with no outputs.
  - ACTIVE: m_ready = 1 (registered, asserted the cycle after start is sampled).
  - start is ignored while ACTIVE.
- Handshake: a beat is accepted on a clock edge where m_valid1 && m_ready.
  - Each accepted beat increments cnt.
  - Accepting beat number size (cnt == size-1) returns the FSM to IDLE; m_ready drops the next cycle.
  - Beats presented while m_ready = 0 are ignored.
  - If m_valid1 = 0 the block stalls; addresses hold.
- Addressing is combinational from registers:
  - m_addr2 = base_reg + cnt, truncated to AW bits (wraps modulo 2^AW).
  - m_addr3 = cnt truncated to AW bits.
  - In IDLE the addresses show base_reg and 0.
- Arithmetic, per lane, signed two's complement:
  - Result = m_data1 + (first_reg ? m_data2 : m_data3).
  - Result is truncated to DW bits (wrap, no saturation).
- Output latency: 1 clock. The result of a beat accepted at edge N appears after edge N.
  - If last_reg = 1: m_sum is loaded and m_valid = 1 for one cycle.
  - Otherwise: s_sum is loaded and s_valid = 1 for one cycle.
  - The unused sum register holds its previous value.
  - The valid outputs are 0 in every cycle with no accepted beat.
- first_k = 1 and last_k = 1 together: bias added, result routed to m_sum.
- Back-to-back beats sustain one result per clock.

Test Plan:
1. Reset: hold rst_n = 0 for 2 clocks -> all outputs 0, m_ready = 0. Pulse start=1 during reset -> ignored.
2. Bias pass (size=8, base2=10, first_k=1, last_k=0, DN=1):
   - Stimulus pairs (m_data1, m_data2): (15,8) (20,11) (-30,-9) (-50,11) (7,1) (5,-17) (99,50) (125,111), followed by extra beats (11,22) (11,22) (12,22) (13,22).
   - Required: s_sum = 23, 31, -39, -39, 8, -12, 149, 236 on consecutive s_valid pulses; m_addr2 steps 10..17; m_valid stays 0.
   - m_ready drops after the 8th beat; the extra beats produce no output.
3. Final pass (size=4, first_k=0, last_k=1): m_data3 = 100 with m_data1 = 1, 2, 3, 4 -> m_sum = 101, 102, 103, 104 with m_valid pulses; m_addr3 steps 0..3; s_valid stays 0.
4. Stall: drop m_valid1 for 3 cycles mid-job -> addresses hold, no valid pulses; the job resumes and completes with the correct count.
5. Wrap and overflow:
   - base2 = 254, size = 4 -> m_addr2 = 254, 255, 0, 1.
   - m_data1 = 2^21-1 with m_data2 = 1 -> s_sum = -2^21.
6. size = 0 start -> no m_ready and no outputs. start pulsed during ACTIVE -> ignored; the running job is unchanged.
